// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU-with-memory subsystem.
package alu_pkg;

  // ALU opcodes carried in the low bits of the instruction's OPER field.
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } op_e;

  // Sequencer states: one instruction takes FETCH, WAIT, EXEC, WB.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  // Result substituted for an opcode the ALU does not implement.
  localparam logic [15:0] BAD_OP_RESULT = 16'hBAD0;
  // Value the ALU itself returns for a divide by zero.
  localparam logic [15:0] DIV0_RESULT   = 16'hDEAD;

  // Instruction word layout {OPER, A, B}.
  localparam int OPER_MSB = 23;
  localparam int OPER_LSB = 16;
  localparam int A_MSB    = 15;
  localparam int A_LSB    = 8;
  localparam int B_MSB    = 7;
  localparam int B_LSB    = 0;
  localparam int OPC_W    = 3;

  // Only the low opcode bits are decoded; everything above OP_DIV is illegal.
  function automatic logic oper_legal(input logic [7:0] oper);
    return (oper[OPC_W-1:0] <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command sequencer: fetches instructions from a synchronous instruction
// memory, drives the combinational ALU and writes each result to the
// result memory. One run per start pulse, ending with a done pulse.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_ops,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [23:0]       imem_rdata,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [7:0]        alu_oper,
  output logic [7:0]        alu_execute,
  input  logic [15:0]       alu_res,
  output logic              rmem_we,
  output logic [ADDR_W-1:0] rmem_addr,
  output logic [15:0]       rmem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt
);

  // Largest meaningful instruction count; larger requests are clamped so a
  // run never addresses past the end of the memories.
  localparam logic [ADDR_W:0] MAX_OPS = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   idx_nxt;
  logic [ADDR_W:0]   num_q;
  logic [15:0]       res_p1;

  assign idx_nxt    = idx_q + 1'b1;
  assign imem_addr  = idx_q[ADDR_W-1:0];
  assign rmem_addr  = idx_q[ADDR_W-1:0];
  assign rmem_wdata = res_p1;

  // State register; reset aborts a run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rmem_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_ops == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        rmem_we = 1'b1;
        state_d = (idx_nxt == num_q) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping, ALU operand registers and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      num_q       <= '0;
      err_cnt     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_oper    <= '0;
      alu_execute <= '0;
      res_p1      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            err_cnt <= '0;
            num_q   <= (num_ops > MAX_OPS) ? MAX_OPS : num_ops;
          end
        end
        // WAIT -> EXEC: instruction word becomes the ALU operands
        S_WAIT: begin
          alu_oper    <= imem_rdata[OPER_MSB:OPER_LSB];
          alu_a       <= imem_rdata[A_MSB:A_LSB];
          alu_b       <= imem_rdata[B_MSB:B_LSB];
          alu_execute <= oper_legal(imem_rdata[OPER_MSB:OPER_LSB]) ? 8'h01 : 8'h00;
        end
        // EXEC -> WB: ALU result (or error marker) captured for write-back
        S_EXEC: begin
          alu_execute <= 8'h00;
          if (oper_legal(alu_oper)) begin
            res_p1 <= alu_res;
            if ((alu_oper[OPC_W-1:0] == 3'(OP_DIV)) && (alu_b == 8'h00))
              err_cnt <= err_cnt + 1'b1;
          end else begin
            res_p1  <= BAD_OP_RESULT;
            err_cnt <= err_cnt + 1'b1;
          end
        end
        S_WB: begin
          idx_q <= idx_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU and
// synchronous instruction memory.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_ops;
  logic [3:0]  imem_addr;
  logic [23:0] imem_rdata;
  logic [7:0]  alu_a, alu_b, alu_oper, alu_execute;
  logic [15:0] alu_res;
  logic        rmem_we;
  logic [3:0]  rmem_addr;
  logic [15:0] rmem_wdata;
  logic        busy, done;
  logic [4:0]  err_cnt;

  alu_seq_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_execute(alu_execute),
    .alu_res(alu_res), .rmem_we(rmem_we), .rmem_addr(rmem_addr),
    .rmem_wdata(rmem_wdata), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with one-cycle read latency.
  logic [23:0] imem [16];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // Behavioural ALU: output only while execute is asserted.
  always_comb begin
    alu_res = 16'h0000;
    if (alu_execute == 8'h01) begin
      case (alu_oper[2:0])
        3'd1: alu_res = {8'h00, alu_a} + {8'h00, alu_b};
        3'd2: alu_res = {8'h00, alu_a} - {8'h00, alu_b};
        3'd3: alu_res = {8'h00, alu_a} * {8'h00, alu_b};
        3'd4: alu_res = (alu_b == 8'h00) ? 16'hDEAD : {8'h00, alu_a / alu_b};
        default: alu_res = 16'h0000;
      endcase
    end
  end

  typedef struct { int cyc; logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] exe; } ex_t;
  typedef struct { int cyc; logic [4:0] err; } dn_t;

  wr_t wr_q[$];
  ex_t ex_q[$];
  dn_t dn_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;

  logic [15:0] exp_data [16];
  logic [7:0]  exp_exec [16];
  int          exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT write, done pulse and EXEC-cycle execute
  // value against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
        chk("missed_write_cycle", cyc, wr_q[0].cyc);
        void'(wr_q.pop_front());
      end
      if (dn_q.size() != 0 && dn_q[0].cyc < cyc) begin
        chk("missed_done_cycle", cyc, dn_q[0].cyc);
        void'(dn_q.pop_front());
      end
      if (ex_q.size() != 0 && ex_q[0].cyc < cyc) void'(ex_q.pop_front());
      if (rmem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {12'h0, rmem_addr, rmem_wdata}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_addr", rmem_addr, e.addr);
          chk("write_data", rmem_wdata, e.data);
          chk("busy_during_write", busy, 1);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          chk("unexpected_done", cyc, 32'hFFFF_FFFF);
        end else begin
          dn_t d;
          d = dn_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err_cnt", err_cnt, d.err);
          chk("busy_at_done", busy, 0);
        end
      end
      if (ex_q.size() != 0 && ex_q[0].cyc == cyc) begin
        ex_t x;
        x = ex_q.pop_front();
        chk("alu_execute_in_exec", alu_execute, x.exe);
      end
    end
  end

  // Issue a start for n instructions and queue the expected responses.
  task automatic issue(input int n);
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    num_ops = 5'(n);
    for (int k = 0; k < n; k++) begin
      wr_q.push_back('{cyc: t0 + 4*k + 4, addr: 4'(k), data: exp_data[k]});
      ex_q.push_back('{cyc: t0 + 4*k + 3, exe: exp_exec[k]});
    end
    dn_q.push_back('{cyc: t0 + 4*n + 1, err: 5'(exp_err)});
    @(negedge clk);
    start = 1'b0;
    num_ops = '0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((dn_q.size() != 0 || wr_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, %0d writes and %0d done pending", name, wr_q.size(), dn_q.size());
      wr_q.delete();
      dn_q.delete();
      ex_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_ops = '0;
    for (int i = 0; i < 16; i++) imem[i] = '0;
    #3;
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_oper", alu_oper, 0);
    chk("rst_alu_execute", alu_execute, 0);
    chk("rst_rmem_we", rmem_we, 0);
    chk("rst_rmem_addr", rmem_addr, 0);
    chk("rst_rmem_wdata", rmem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_write", rmem_we, 0);
    end

    // Basic run: ADD 5,3; SUB 9,4; MUL 12,12; DIV 100,7
    imem[0] = {8'h01, 8'd5, 8'd3};    exp_data[0] = 16'd8;   exp_exec[0] = 8'h01;
    imem[1] = {8'h02, 8'd9, 8'd4};    exp_data[1] = 16'd5;   exp_exec[1] = 8'h01;
    imem[2] = {8'h03, 8'd12, 8'd12};  exp_data[2] = 16'd144; exp_exec[2] = 8'h01;
    imem[3] = {8'h04, 8'd100, 8'd7};  exp_data[3] = 16'd14;  exp_exec[3] = 8'h01;
    exp_err = 0;
    issue(4);
    wait_done("basic");

    // Errors: DIV 10,0; illegal opcode 6; ADD 255,255
    imem[0] = {8'h04, 8'd10, 8'd0};   exp_data[0] = 16'hDEAD; exp_exec[0] = 8'h01;
    imem[1] = {8'h06, 8'd1, 8'd1};    exp_data[1] = 16'hBAD0; exp_exec[1] = 8'h00;
    imem[2] = {8'h01, 8'd255, 8'd255}; exp_data[2] = 16'd510; exp_exec[2] = 8'h01;
    exp_err = 2;
    issue(3);
    wait_done("errors");
    repeat (3) @(negedge clk);
    chk("err_cnt_held", err_cnt, 2);

    // Zero-length run clears err_cnt and finishes in cycle 1
    exp_err = 0;
    issue(0);
    wait_done("zero_ops");
    chk("zero_ops_busy", busy, 0);

    // Full-depth run; upper OPER bits are ignored by the decode
    for (int i = 0; i < 16; i++) begin
      imem[i] = {8'hF9, 8'(i), 8'(i)};
      exp_data[i] = 16'(2 * i);
      exp_exec[i] = 8'h01;
    end
    exp_err = 0;
    issue(16);
    wait_done("full_depth");

    // Start pulsed mid-run is ignored
    imem[0] = {8'h01, 8'd5, 8'd3};    exp_data[0] = 16'd8;
    imem[1] = {8'h02, 8'd9, 8'd4};    exp_data[1] = 16'd5;
    imem[2] = {8'h03, 8'd12, 8'd12};  exp_data[2] = 16'd144;
    imem[3] = {8'h04, 8'd100, 8'd7};  exp_data[3] = 16'd14;
    exp_err = 0;
    issue(4);
    repeat (4) @(negedge clk);
    start = 1'b1;
    num_ops = 5'd1;
    @(negedge clk);
    start = 1'b0;
    num_ops = '0;
    wait_done("start_ignored");

    // Reset during WB of the second instruction of an erroring run
    imem[0] = {8'h04, 8'd10, 8'd0};   exp_data[0] = 16'hDEAD; exp_exec[0] = 8'h01;
    imem[1] = {8'h06, 8'd1, 8'd1};    exp_data[1] = 16'hBAD0; exp_exec[1] = 8'h00;
    imem[2] = {8'h01, 8'd255, 8'd255}; exp_data[2] = 16'd510; exp_exec[2] = 8'h01;
    exp_err = 2;
    issue(3);
    for (int k = 0; k < 20 && cyc != t0 + 8; k++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rmem_we", rmem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_alu_execute", alu_execute, 0);
    wr_q.delete();
    dn_q.delete();
    ex_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1;
    issue(1);
    wait_done("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer that drives the combinational ALU from a program held in a synchronous instruction memory and writes each 16-bit ALU result to a result memory. It is the issuing side of the ALU operand/opcode/execute interface. It sits between the instruction memory, the ALU and the result memory in the ALU-with-memory subsystem. One run is started by a `start` pulse and ends with a `done` pulse.

## Interface
- `DEPTH`, 16: number of instruction and result memory entries.
- `ADDR_W`, 4: memory address width; DEPTH = 2**ADDR_W.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle run request; sampled only in IDLE.
- `num_ops` in ADDR_W+1: number of instructions to execute (0..DEPTH); sampled with `start`.
- `imem_addr` out ADDR_W: instruction memory read address.
- `imem_rdata` in 24: instruction word {OPER[23:16], A[15:8], B[7:0]}; valid one cycle after the address (synchronous read).
- `alu_a`, `alu_b`, `alu_oper`, `alu_execute` out 8 each: registered ALU inputs.
- `alu_res` in 16: ALU result (combinational from the `alu_*` outputs).
- `rmem_we` out 1: result memory write enable.
- `rmem_addr` out ADDR_W: result write address.
- `rmem_wdata` out 16: result write data.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the run completes.
- `err_cnt` out ADDR_W+1: count of divide-by-zero and illegal-opcode instructions in the current or last run.

## Operation
- **States:** IDLE → FETCH → WAIT → EXEC → WB, then either FETCH (more instructions) or FIN → IDLE.
- **IDLE:**
  - On `start`=1 with `num_ops`≠0: latch `num_ops`, clear the index and `err_cnt`, go to FETCH.
  - On `start`=1 with `num_ops`=0: clear `err_cnt` and go to FIN.
- **FETCH:** `imem_addr` = index.
- **WAIT:** memory latency cycle. At the end of WAIT, `imem_rdata` is loaded into the `alu_a`, `alu_b` and `alu_oper` registers.
- **EXEC:**
  - Drive `alu_execute` = 8'h01 when OPER[2:0] ≤ 3'b100, otherwise 8'h00.
  - At the end of EXEC, register the result:
    - legal opcode: `alu_res`.
    - OPER[2:0] ≥ 3'b101: 16'hBAD0, and `err_cnt` += 1.
    - OPER[2:0] = 3'b100 with B = 0: the ALU returns 16'hDEAD; write that value and `err_cnt` += 1.
  - Only OPER[2:0] is decoded; OPER[7:3] is ignored but passed through to `alu_oper`.
- **WB:**
  - `rmem_we` = 1, `rmem_addr` = index, `rmem_wdata` = registered result.
  - Then index += 1. If index = latched `num_ops`, go to FIN; otherwise go to FETCH.
- **FIN:** `done` = 1 for one cycle, `busy` = 0 in the same cycle, then IDLE. `alu_execute` returns to 0 outside EXEC.
- **Start handling:** `start` in any state other than IDLE is ignored; runs do not queue.
- **Error counter:** `err_cnt` holds its value after `done` until the next accepted `start`. It cannot overflow because the count is bounded by DEPTH.
- **Reset:** asserting `rst_n` low mid-run aborts immediately and asynchronously. `rmem_we` drops in the same instant. There is no partial-write recovery.

## Timing
- **Reset values:** every output is 0, the state is IDLE and the index is 0.
- **Per instruction:** 4 cycles (FETCH, WAIT, EXEC, WB).
- A run of N≥1 instructions:
  - `start` is sampled at edge 0.
  - The first `rmem_we` is high in cycle 4.
  - The last `rmem_we` is high in cycle 4N.
  - `done` is high in cycle 4N+1.
  - `busy` is high in cycles 1..4N.
- A run with N=0: `done` is high in cycle 1 and `busy` never rises.
- `alu_*` outputs are stable for the whole EXEC cycle; `alu_res` is sampled only at the end of EXEC.
- **Addressing:** no wrap-around. With `num_ops`=DEPTH, the last access is address DEPTH-1 and the index then equals DEPTH = `num_ops`, so the run ends.

## Structure
- **Shared package `alu_pkg`:**
  - opcode enum: OP_NOP=0, OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - sequencer state enum.
  - constants DIV0_RESULT=16'hDEAD and BAD_OP_RESULT=16'hBAD0.
  - instruction field bit positions.
- **Sub-modules:** none. A single FSM module is sufficient; the ALU and both memories are instantiated beside it at the subsystem top.

## Test plan
- **Reset:** `rst_n` low → all outputs 0 and `busy`=0. Release reset and hold `start` low for 10 cycles → no `rmem_we`.
- **Basic run:** program {ADD 5,3}, {SUB 9,4}, {MUL 12,12}, {DIV 100,7}; `num_ops`=4 → rmem[0..3] = 8, 5, 144, 14; `done` in cycle 17; `err_cnt`=0.
- **Errors:** {DIV 10,0}, {OPER=8'h06, 1, 1}, {ADD 255,255} → rmem = 16'hDEAD, 16'hBAD0, 510; `err_cnt`=2; `alu_execute`=0 during EXEC of the second instruction.
- **Boundaries:**
  - `num_ops`=0 → `done` in cycle 1 with no writes.
  - `num_ops`=16 → writes to addresses 0..15 and `done` in cycle 65.
- **Start during a run:** `start` pulsed while `busy` → ignored; the run completes with the original `num_ops`.
- **Reset mid-run:** `rst_n` low during WB of instruction 2 → `rmem_we` drops immediately, the FSM is in IDLE, a new `start` runs from index 0, and `err_cnt` is cleared.
